jt51_wrseq: RTL
===============

JT51_WRSEQ -- requirements
Module: jt51_wrseq

Interface
REQ-001 Parameter AW, default 3, log2 of write-queue depth (8 entries).
REQ-002 Parameter SKIP_ADDR, default 1, omit address write when the address equals the last address written.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 host_addr  input  8  register address of queued write.
REQ-006 host_data  input  8  register data of queued write.
REQ-007 host_valid  input  1  host offers {host_addr, host_data}.
REQ-008 host_ready  output  1  queue can accept; equals !full.
REQ-009 flush  input  1  synchronous discard of all not-yet-popped entries.
REQ-010 busy_in  input  1  busy flag from the register file.
REQ-011 write  output  1  write strobe to the register file.
REQ-012 a0  output  1  0 = address cycle, 1 = data cycle.
REQ-013 dout  output  8  address or data byte to the register file.
REQ-014 level  output  AW+1  number of queued entries, 0..2^AW.
REQ-015 empty  output  1  level == 0.
REQ-016 idle  output  1  queue empty and FSM in IDLE.

Function
REQ-017 Push occurs on an edge with host_valid && host_ready && !flush; host_addr and host_data are stored as one entry.
REQ-018 Pointers wrap modulo 2^AW; level is tracked separately so the full and empty states are distinct.
REQ-019 Simultaneous push and pop leaves level unchanged; a push when full is impossible because host_ready is 0.
REQ-020 flush sets level to 0 and equalises the pointers; the transaction already popped completes normally; a push in the same cycle is ignored.
REQ-021 FSM states: IDLE, ADDR, GAP, DATA, HOLD, WAITB.
REQ-022 IDLE: if !empty, pop the head entry into the hold registers; go to DATA if SKIP_ADDR && last_valid && addr == last_addr; otherwise go to ADDR.
REQ-023 ADDR: write=1, a0=0, dout=addr; last_addr<=addr, last_valid<=1; go to GAP.
REQ-024 GAP: write=0, a0=0; go to DATA. This guarantees a low cycle before the data strobe so the register file detects the rising edge of write.
REQ-025 DATA: write=1, a0=1, dout=data; go to HOLD.
REQ-026 HOLD: write=0; busy_in is ignored, covering the register file's one-clock busy-set latency; go to WAITB.
REQ-027 WAITB: write=0; go to IDLE when busy_in==0; stay while busy_in==1, with no timeout.
REQ-028 write, a0 and dout are registered and reflect the current state only; write is never high for two consecutive cycles.
REQ-029 In all non-strobe states dout holds its last value and a0 is 0.
REQ-030 Latency: if the entry is accepted at edge n while IDLE and empty, the FSM enters ADDR at edge n+2, so write is first high in the cycle after edge n+2; the data strobe follows 2 cycles later (0 cycles later when the address is skipped).
REQ-031 Throughput: the minimum interval between data strobes is 4 cycles plus the busy_in duration, plus 2 cycles when the address is not skipped.
REQ-032 Writes leave the block in push order; none are dropped except by flush.

Reset
REQ-033 rst asserted: state=IDLE; level=0; pointers=0; write=0; a0=0; dout=0x00; last_addr=0x00; last_valid=0; host_ready=1; empty=1; idle=1.
REQ-034 rst mid-transaction aborts it immediately, with write low from assertion onward; queued entries are lost.
REQ-035 After rst the first transaction always performs the address cycle.

Verification
REQ-036 Single push (0x14, 0x15) into an idle block -> write/a0/dout sequence: (1,0,0x14), (0,0,-), (1,1,0x15), then write=0 until busy_in has risen and fallen; idle=1 afterwards.
REQ-037 Two pushes to 0x28 with data 0x4A then 0x4B, SKIP_ADDR=1 -> exactly one address strobe and two data strobes, the second no earlier than the first cycle of busy_in==0.
REQ-038 Push 9 entries back-to-back with busy_in held high -> host_ready=0 at level 8; the 9th is accepted only after a pop; all 9 emerge in order.
REQ-039 Queue 5 entries, pulse flush while the first is in WAITB -> the first completes, the others never appear, and level=0 the cycle after flush.
REQ-040 Assert rst during DATA -> write=0 immediately; after release with level=0, a new push to the previous address still emits its address strobe.
REQ-041 Random pushes with random busy_in lengths -> the scoreboard matches order and content; write is never high on 2 consecutive cycles, and no data strobe occurs while busy_in=1.

Source files
------------

// File: rtl/jt51_wrseq.sv
// Queued register-write sequencer for the JT51 register file: buffers host writes and
// replays each as an address strobe, a guaranteed low cycle, then a data strobe.
//
// state | meaning
// IDLE  | waiting for a queued entry; pops the head when one is available
// ADDR  | address strobe (write=1, a0=0)
// GAP   | write low so the register file sees a fresh rising edge for the data strobe
// DATA  | data strobe (write=1, a0=1)
// HOLD  | covers the one-clock delay before the register file raises busy
// WAITB | waits for busy_in to fall
module jt51_wrseq #(
    parameter int AW        = 3,
    parameter bit SKIP_ADDR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    host_addr,
    input  logic [7:0]    host_data,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          flush,
    input  logic          busy_in,
    output logic          write,
    output logic          a0,
    output logic [7:0]    dout,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          idle
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_HOLD,
        S_WAITB
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_mem_addr [DEPTH];
    logic [7:0]    r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_pend;

    logic [7:0]    r_hold_addr;
    logic [7:0]    r_hold_data;
    logic [7:0]    r_last_addr;
    logic          r_last_valid;

    logic          r_write;
    logic          r_a0;
    logic [7:0]    r_dout;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_skip;
    logic          w_write_nxt;
    logic          w_a0_nxt;
    logic [7:0]    w_dout_nxt;
    logic [7:0]    w_head_addr;
    logic [7:0]    w_head_data;

    assign w_full      = (r_level == FULL_LEVEL);
    assign w_empty     = (r_level == '0);
    assign w_push      = host_valid && !w_full && !flush;
    assign w_head_addr = r_mem_addr[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];
    assign w_skip      = SKIP_ADDR && r_last_valid && (w_head_addr == r_last_addr);

    assign host_ready = !w_full;
    assign empty      = w_empty;
    assign level      = r_level;
    assign idle       = w_empty && (r_state == S_IDLE);
    assign write      = r_write;
    assign a0         = r_a0;
    assign dout       = r_dout;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= host_addr;
            r_mem_data[r_wptr] <= host_data;
        end
    end

    // r_pend lags the level by one clock, so IDLE only pops an entry that has settled a full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= !w_empty;
            if (flush) begin
                r_rptr  <= r_wptr;
                r_level <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)      r_level <= r_level + 1'b1;
                else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            end
        end
    end

    // Strobe outputs are computed for the state being entered, so they register in step with it.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_write_nxt = 1'b0;
        w_a0_nxt    = 1'b0;
        w_dout_nxt  = r_dout;
        case (r_state)
            S_IDLE: begin
                if (r_pend && !w_empty && !flush) begin
                    w_pop       = 1'b1;
                    w_write_nxt = 1'b1;
                    if (w_skip) begin
                        w_state_nxt = S_DATA;
                        w_a0_nxt    = 1'b1;
                        w_dout_nxt  = w_head_data;
                    end else begin
                        w_state_nxt = S_ADDR;
                        w_dout_nxt  = w_head_addr;
                    end
                end
            end
            S_ADDR:  w_state_nxt = S_GAP;
            S_GAP: begin
                w_state_nxt = S_DATA;
                w_write_nxt = 1'b1;
                w_a0_nxt    = 1'b1;
                w_dout_nxt  = r_hold_data;
            end
            S_DATA:  w_state_nxt = S_HOLD;
            S_HOLD:  w_state_nxt = S_WAITB;
            S_WAITB: if (!busy_in) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_a0         <= 1'b0;
            r_dout       <= 8'h00;
            r_hold_addr  <= 8'h00;
            r_hold_data  <= 8'h00;
            r_last_addr  <= 8'h00;
            r_last_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_write <= w_write_nxt;
            r_a0    <= w_a0_nxt;
            r_dout  <= w_dout_nxt;
            if (w_pop) begin
                r_hold_addr <= w_head_addr;
                r_hold_data <= w_head_data;
            end
            if (r_state == S_ADDR) begin
                r_last_addr  <= r_hold_addr;
                r_last_valid <= 1'b1;
            end
        end
    end

endmodule
